// File: rtl/safe_pkg.sv
// Shared types and constants for the safe keypad path.
package safe_pkg;

    typedef logic [3:0] key_t;

    localparam key_t IDLE_CODE = 4'hF;
    localparam key_t KEY_STAR  = 4'hA;
    localparam key_t KEY_HASH  = 4'hB;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } kef_state_t;

endpackage

// File: rtl/key_fifo.sv
// Small circular FIFO for key events; head is read straight from the storage flops.
module key_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty   = (wr_q == rd_q);
    assign level   = wr_q - rd_q;
    assign head    = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    // Next pointer and storage values.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = push_data;
            wr_d                = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    // Pointer and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '{default: '0};
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/key_event_filter.sv
// Synchronises and debounces the scanner key code; one FIFO event per physical press.
module key_event_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter logic [3:0]  IDLE_CODE       = safe_pkg::IDLE_CODE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [3:0]                    data_in,
    input  logic                          key_ready,
    input  logic                          clr_ovf,
    output logic                          key_valid,
    output logic [3:0]                    key_data,
    output logic                          overflow,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    import safe_pkg::*;

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    key_t             sync1_q, sync1_d;
    key_t             sync2_q, sync2_d;
    key_t             cand_q, cand_d;
    kef_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign key_valid = ~empty;
    assign pop       = key_valid & key_ready;
    assign busy      = (state_q != IDLE);
    assign overflow  = ovf_q;

    // Two-stage synchroniser on the raw scanner code.
    always_comb begin
        sync1_d = data_in;
        sync2_d = sync1_q;
    end

    // Debounce FSM: next state, counter, candidate and push strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q != IDLE_CODE) begin
                    cand_d  = sync2_q;
                    cnt_d   = CNT_W'(1);
                    state_d = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (sync2_q == cand_q) begin
                    if (cnt_q == CNT_LAST) begin
                        push    = 1'b1;
                        cnt_d   = '0;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            HELD: begin
                if (sync2_q == IDLE_CODE) begin
                    cnt_d   = CNT_W'(1);
                    state_d = DEB_RELEASE;
                end
            end
            DEB_RELEASE: begin
                if (sync2_q == IDLE_CODE) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = HELD;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= IDLE_CODE;
            sync2_q <= IDLE_CODE;
            cand_q  <= IDLE_CODE;
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (cand_q),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level),
        .head      (key_data)
    );

endmodule

// File: tb/tb_key_event_filter.sv
// Self-checking bench for key_event_filter: vector table plus hand-written corner sequences.
module tb_key_event_filter;

    logic       clk;
    logic       rst_n;
    logic [3:0] data_in;
    logic       key_ready;
    logic       clr_ovf;
    logic       key_valid;
    logic [3:0] key_data;
    logic       overflow;
    logic       busy;
    logic [2:0] fifo_level;

    int n_cmp;
    int n_err;
    int n_events;
    int snap;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [3:0] code;
        int         hold;
        int         bounces;
        int         rel_bounces;
        int         exp_n;
    } vec_t;

    vec_t vecs[6];

    key_event_filter #(
        .DEBOUNCE_CYCLES (4),
        .FIFO_DEPTH      (4),
        .IDLE_CODE       (4'hF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .key_ready  (key_ready),
        .clr_ovf    (clr_ovf),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .overflow   (overflow),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code, input int hold, input int bounces, input int rel_bounces);
        for (int b = 0; b < bounces; b++) begin
            data_in = code;  step(2);
            data_in = 4'hF;  step(2);
        end
        data_in = code;
        step(hold);
        for (int b = 0; b < rel_bounces; b++) begin
            data_in = 4'hF;  step(2);
            data_in = code;  step(2);
        end
        data_in = 4'hF;
        step(10);
    endtask

    // Scoreboard: every handshake pops one expected code.
    always @(negedge clk) begin
        if (rst_n && key_valid && key_ready) begin
            n_events++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_event: got %0h expected none at %0t", key_data, $time);
            end else begin
                check("event_data", key_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        n_cmp = 0; n_err = 0; n_events = 0;
        vecs[0] = '{code: 4'h3, hold: 8,  bounces: 5, rel_bounces: 0, exp_n: 1};
        vecs[1] = '{code: 4'h0, hold: 4,  bounces: 0, rel_bounces: 0, exp_n: 1};
        vecs[2] = '{code: 4'h7, hold: 3,  bounces: 0, rel_bounces: 0, exp_n: 0};
        vecs[3] = '{code: 4'hA, hold: 10, bounces: 2, rel_bounces: 2, exp_n: 1};
        vecs[4] = '{code: 4'hB, hold: 6,  bounces: 0, rel_bounces: 3, exp_n: 1};
        vecs[5] = '{code: 4'h9, hold: 20, bounces: 1, rel_bounces: 1, exp_n: 1};

        // Asynchronous reset, observed before any clock edge.
        rst_n = 1'b0; data_in = 4'hF; key_ready = 1'b0; clr_ovf = 1'b0;
        #2;
        check("rst_key_valid", key_valid, 0);
        check("rst_key_data", key_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // Clean press: latency and single-cycle valid pulse.
        key_ready = 1'b1;
        exp_q.push_back(4'h5);
        snap = n_events;
        data_in = 4'h5;
        step(5);
        check("lat_valid_e5", key_valid, 0);
        step(1);
        check("lat_valid_e6", key_valid, 1);
        check("lat_data_e6", key_data, 4'h5);
        step(1);
        check("lat_valid_e7", key_valid, 0);
        check("held_busy", busy, 1);
        step(13);
        data_in = 4'hF;
        step(10);
        check("clean_busy_done", busy, 0);
        check("clean_events", n_events - snap, 1);

        // Table of presses with press and release bounce.
        foreach (vecs[i]) begin
            snap = n_events;
            if (vecs[i].exp_n != 0) exp_q.push_back(vecs[i].code);
            press(vecs[i].code, vecs[i].hold, vecs[i].bounces, vecs[i].rel_bounces);
            check($sformatf("vec%0d_events", i), n_events - snap, vecs[i].exp_n);
        end

        // Rollover: second key while first is held is ignored.
        snap = n_events;
        exp_q.push_back(4'h7);
        data_in = 4'h7; step(10);
        data_in = 4'h8; step(10);
        data_in = 4'hF; step(10);
        check("rollover_events", n_events - snap, 1);
        check("rollover_busy", busy, 0);

        // Buffering with overflow; drop and clear in the same cycle.
        key_ready = 1'b0;
        press(4'h1, 6, 0, 0); exp_q.push_back(4'h1);
        press(4'h2, 6, 0, 0); exp_q.push_back(4'h2);
        press(4'h3, 6, 0, 0); exp_q.push_back(4'h3);
        press(4'h4, 6, 0, 0); exp_q.push_back(4'h4);
        check("buf_level_full", fifo_level, 4);
        check("buf_ovf_before", overflow, 0);
        data_in = 4'h9;
        step(5);
        check("buf_ovf_e5", overflow, 0);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        check("buf_ovf_drop_wins", overflow, 1);
        check("buf_level_after_drop", fifo_level, 4);
        step(2);
        data_in = 4'hF;
        step(10);
        check("buf_head", key_data, 4'h1);
        key_ready = 1'b1;
        step(6);
        key_ready = 1'b0;
        check("buf_level_drained", fifo_level, 0);
        check("buf_ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        check("buf_ovf_cleared", overflow, 0);

        // Full FIFO with a pop on the push cycle: no drop.
        press(4'h1, 6, 0, 0); exp_q.push_back(4'h1);
        press(4'h2, 6, 0, 0); exp_q.push_back(4'h2);
        press(4'h3, 6, 0, 0); exp_q.push_back(4'h3);
        press(4'h4, 6, 0, 0); exp_q.push_back(4'h4);
        exp_q.push_back(4'h6);
        data_in = 4'h6;
        step(5);
        key_ready = 1'b1;
        step(1);
        key_ready = 1'b0;
        check("fullpop_level", fifo_level, 4);
        check("fullpop_ovf", overflow, 0);
        step(4);
        data_in = 4'hF;
        step(10);
        key_ready = 1'b1;
        step(6);
        key_ready = 1'b0;
        check("fullpop_drained", fifo_level, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        // Reset mid-debounce with events queued.
        press(4'h4, 6, 0, 0);
        press(4'h5, 6, 0, 0);
        check("mid_level", fifo_level, 2);
        data_in = 4'h2;
        step(3);
        check("mid_busy", busy, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", key_valid, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_busy", busy, 0);
        data_in = 4'hF;
        step(2);
        rst_n = 1'b1;
        key_ready = 1'b1;
        snap = n_events;
        step(15);
        check("post_rst_valid", key_valid, 0);
        check("post_rst_events", n_events - snap, 0);
        check("post_rst_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
